paro_stream_fifo: RTL and testbench

- Memory-mapped, buffered byte-stream output peripheral on one data-bus slave port.
- Core writes bytes into an internal FIFO. A drain FSM presents them on an 8-bit parallel port with a valid strobe of programmable length, followed by a programmable idle gap.
- Sits between the bus mux slave port and the chip ParO pins. Replaces unbuffered parallel output where the core must not stall per byte.

---
 rtl/paro_stream_pkg.sv | 34 +++
 rtl/paro_stream_fifo_sync_fifo.sv | 49 ++++
 rtl/paro_stream_fifo.sv | 212 +++++++++++++++++++++
 tb/tb_paro_stream_fifo.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paro_stream_pkg.sv
// Shared register map, field positions and drain FSM encoding for paro_stream_fifo.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package paro_stream_pkg;

  // Register indices, decoded from addr_i[ADDR_LSB+1:ADDR_LSB]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS fields
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_IRQ   = 3;
  localparam int ST_LEVEL = 8;
  localparam int LEVEL_W  = 7;

  // CTRL fields
  localparam int CT_EN     = 0;
  localparam int CT_FLUSH  = 1;
  localparam int CT_HOLD   = 8;
  localparam int CT_GAP    = 16;
  localparam int CT_THRESH = 24;
  localparam int THRESH_W  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } drain_state_e;

endpackage

// File: rtl/paro_stream_fifo_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, head-of-queue read port and flush.
// Latency: push visible at data_o/empty_o one cycle later; pop retires the head on the edge.
// Backpressure: none internally; caller must not push when full (unless popping) or pop when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;

  // Pointer update; flush wins over any push/pop in the same cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage array, no reset needed since empty/full gate every read
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o = wr_q - rd_q;

endmodule

// File: rtl/paro_stream_fifo.sv
// Bus-mapped buffered byte-stream output: FIFO plus drain FSM with programmable hold/gap.
// Latency: DATA write in cycle N reaches par_valid_o in N+2 when idle and enabled; bus response N+1.
// Backpressure: bus never stalls; pushes to a full FIFO are dropped with err_o and sticky overflow.
// Optional: PARO_FIFO_IRQ_EN adds irq_o and the CTRL thresh field.
module paro_stream_fifo
  import paro_stream_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int HOLD_W   = 4,
  parameter int ADDR_LSB = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [7:0]  par_o,
`ifdef PARO_FIFO_IRQ_EN
  output logic        irq_o,
`endif
  output logic        par_valid_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [HOLD_W-1:0] ONE = HOLD_W'(1);

  logic [1:0]  idx;
  logic        wr_acc, rd_acc, push_req, flush, push_ok, ovf_set, pop;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_level;
  logic [7:0]  fifo_head;

  logic              en_q, ovf_q;
  logic [HOLD_W-1:0] hold_q, gap_q, hold_eff;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [7:0]        par_q, par_d;
  drain_state_e      state_q, state_d;

  logic              rvalid_q, err_q, err_d;
  logic [31:0]       rdata_q, rd_val;
  logic              irq_rd;
  logic [THRESH_W-1:0] thresh_rd;
  logic              unused_bits;

  assign idx      = addr_i[ADDR_LSB+1:ADDR_LSB];
  assign wr_acc   = req_i & we_i;
  assign rd_acc   = req_i & ~we_i;
  assign push_req = wr_acc && (idx == REG_DATA) && be_i[0];
  assign flush    = wr_acc && (idx == REG_CTRL) && be_i[0] && wdata_i[CT_FLUSH];
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push_ok  = push_req && !flush && (!fifo_full || pop);
  assign ovf_set  = push_req && !flush && fifo_full && !pop;
  assign hold_eff = (hold_q == '0) ? ONE : hold_q;
  assign unused_bits = ^{addr_i, wdata_i, be_i};

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_ok),
    .data_i  (wdata_i[7:0]),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // CTRL and sticky overflow registers, byte-lane qualified
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q   <= 1'b0;
      hold_q <= ONE;
      gap_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_acc && idx == REG_CTRL) begin
        if (be_i[0]) en_q   <= wdata_i[CT_EN];
        if (be_i[1]) hold_q <= wdata_i[CT_HOLD +: HOLD_W];
        if (be_i[2]) gap_q  <= wdata_i[CT_GAP +: HOLD_W];
      end
      if (ovf_set) ovf_q <= 1'b1;
      else if (wr_acc && idx == REG_STATUS && be_i[0] && wdata_i[ST_OVF]) ovf_q <= 1'b0;
    end
  end

  // Drain FSM state, counter and output byte registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      par_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

  // Drain FSM next-state: pop in IDLE, count hold in DRIVE, count gap in GAP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_q && !fifo_empty) begin
            pop     = 1'b1;
            par_d   = fifo_head;
            cnt_d   = hold_eff;
            state_d = DRIVE;
          end
        end
        DRIVE: begin
          if (cnt_q <= ONE) begin
            if (gap_q != '0) begin
              cnt_d   = gap_q;
              state_d = GAP;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        GAP: begin
          if (cnt_q <= ONE) state_d = IDLE;
          else              cnt_d   = cnt_q - ONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign par_o       = par_q;
  assign par_valid_o = (state_q == DRIVE);

`ifdef PARO_FIFO_IRQ_EN
  logic [THRESH_W-1:0] thresh_q;
  logic                irq_q;

  // Threshold register and registered interrupt
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_acc && idx == REG_CTRL && be_i[3]) thresh_q <= wdata_i[CT_THRESH +: THRESH_W];
      irq_q <= (en_q && (LEVEL_W'(fifo_level) <= thresh_q)) || ovf_q;
    end
  end

  assign irq_o     = irq_q;
  assign irq_rd    = irq_q;
  assign thresh_rd = thresh_q;
`else
  assign irq_rd    = 1'b0;
  assign thresh_rd = '0;
`endif

  // Read data mux for the current request
  always_comb begin
    rd_val = '0;
    case (idx)
      REG_STATUS: begin
        rd_val[ST_EMPTY]            = fifo_empty;
        rd_val[ST_FULL]             = fifo_full;
        rd_val[ST_OVF]              = ovf_q;
        rd_val[ST_IRQ]              = irq_rd;
        rd_val[ST_LEVEL +: LEVEL_W] = LEVEL_W'(fifo_level);
      end
      REG_CTRL: begin
        rd_val[CT_EN]                 = en_q;
        rd_val[CT_HOLD +: HOLD_W]     = hold_q;
        rd_val[CT_GAP +: HOLD_W]      = gap_q;
        rd_val[CT_THRESH +: THRESH_W] = thresh_rd;
      end
      default: rd_val = '0;
    endcase
  end

  assign err_d = (wr_acc && idx == REG_RSVD) || ovf_set;

  // One-cycle bus response; data and error are zero outside rvalid
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= req_i;
      rdata_q  <= rd_acc ? rd_val : '0;
      err_q    <= req_i && err_d;
    end
  end

  assign gnt_o    = req_i;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_paro_stream_fifo.sv
// Directed plus randomized bench for paro_stream_fifo against a transaction-level model.
// Latency: checks N+1 bus response and N+2 strobe start.
// Backpressure: exercises overflow, push-on-pop and flush.
module tb_paro_stream_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = '0, wdata = '0;
  logic        gnt, rvalid, err, par_valid;
  logic [31:0] rdata;
  logic [7:0]  par;
`ifdef PARO_FIFO_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  paro_stream_fifo #(.DEPTH(DEPTH), .HOLD_W(4), .ADDR_LSB(2)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .rvalid_o(rvalid),
    .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata),
    .err_o(err), .par_o(par),
`ifdef PARO_FIFO_IRQ_EN
    .irq_o(irq),
`endif
    .par_valid_o(par_valid)
  );

  int checks = 0;
  int failures = 0;

  // Monitor: records every strobe's byte, length and start cycle
  int         cyc = 0;
  logic [7:0] obs_b[$];
  int         obs_len[$];
  int         obs_rise[$];
  bit         pv_prev = 1'b0;
  int         run = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      pv_prev = 1'b0;
      run = 0;
    end else begin
      if (par_valid) begin
        if (!pv_prev) begin
          obs_b.push_back(par);
          obs_rise.push_back(cyc);
          run = 1;
        end else run++;
      end else if (pv_prev) obs_len.push_back(run);
      pv_prev = par_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [31:0] ctrl(input bit en, input bit fl, input int hold, input int gap, input int th);
    logic [31:0] r;
    r = '0;
    r[0] = en;
    r[1] = fl;
    r[11:8] = hold[3:0];
    r[19:16] = gap[3:0];
    r[30:24] = th[6:0];
    return r;
  endfunction

  function automatic logic [31:0] stat(input bit e, input bit f, input bit o, input int lvl);
    logic [31:0] r;
    r = '0;
    r[0] = e;
    r[1] = f;
    r[2] = o;
    r[14:8] = lvl[6:0];
    return r;
  endfunction

  // One bus transaction starting at a negedge; returns at the response negedge
  task automatic bus(input logic w, input logic [1:0] idx, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er);
    req = 1'b1; we = w; addr = {28'h0, idx, 2'b00}; be = 4'hF; wdata = wd;
    #1 chk("gnt", {31'h0, gnt}, 32'h1);
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = 4'h0;
    chk("rvalid", {31'h0, rvalid}, 32'h1);
    rd = rdata;
    er = err;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] wd);
    logic [31:0] rd;
    logic er;
    bus(1'b1, idx, wd, rd, er);
  endtask

  // STATUS read with the irq mirror bit masked out
  task automatic rd_status(input string tag, input logic [31:0] exp);
    logic [31:0] rd;
    logic er;
    bus(1'b0, 2'd1, 32'h0, rd, er);
    chk(tag, rd & ~32'h8, exp);
  endtask

  task automatic clear_mon();
    obs_b.delete();
    obs_len.delete();
    obs_rise.delete();
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k;
    k = 0;
    while (obs_b.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_budget", {31'h0, (obs_b.size() >= n)}, 32'h1);
    repeat (25) @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [7:0]  model[$];
  int          hold, gap, n, heff, k;
  bit          exp_v;
  logic [7:0]  exp_b;

  initial begin
    // ---- reset state ----
    #2;
    chk("rst_par", {24'h0, par}, 32'h0);
    chk("rst_pvalid", {31'h0, par_valid}, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // en=1 preloaded and a byte in flight, then asynchronous reset
    wr(2'd2, ctrl(1, 0, 15, 0, 0));
    wr(2'd0, 32'h77);
    k = 0;
    while (!par_valid && k < 10) begin @(negedge clk); k++; end
    chk("pre_rst_strobe", {24'h0, par}, 32'h77);
    #2 rst = 1'b1;
    #1;
    chk("arst_pvalid", {31'h0, par_valid}, 32'h0);
    chk("arst_par", {24'h0, par}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus(1'b0, 2'd1, 32'h0, rd, er);
    chk("rst_status", rd, 32'h1);
    bus(1'b0, 2'd2, 32'h0, rd, er);
    chk("rst_ctrl", rd, ctrl(0, 0, 1, 0, 0));
    @(negedge clk);
    chk("idle_rvalid", {31'h0, rvalid}, 32'h0);
    chk("idle_rdata", rdata, 32'h0);
    repeat (3) @(negedge clk);
    clear_mon();

    // ---- hold 3, gap 2: exact waveform ----
    wr(2'd2, ctrl(1, 0, 3, 2, 0));
    wr(2'd0, 32'hA5);
    wr(2'd0, 32'h3C);
    for (int i = 0; i < 10; i++) begin
      exp_v = ((i % 6) < 3) && (i < 9);
      exp_b = (i < 6) ? 8'hA5 : 8'h3C;
      chk("wave_valid", {31'h0, par_valid}, {31'h0, exp_v});
      chk("wave_byte", {24'h0, par}, {24'h0, exp_b});
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("wave_count", obs_b.size(), 2);

    // ---- overflow, sticky clear, flush keeps overflow, register map ----
    wr(2'd2, ctrl(0, 0, 1, 0, 0));
    for (int i = 0; i <= DEPTH; i++) begin
      bus(1'b1, 2'd0, i, rd, er);
      chk("ovf_err", {31'h0, er}, (i == DEPTH) ? 32'h1 : 32'h0);
    end
    rd_status("st_full_ovf", stat(0, 1, 1, DEPTH));
    wr(2'd1, 32'h4);
    rd_status("st_ovf_clr", stat(0, 1, 0, DEPTH));
    bus(1'b1, 2'd0, 32'hEE, rd, er);
    chk("ovf_err2", {31'h0, er}, 32'h1);
    wr(2'd2, ctrl(0, 1, 1, 0, 0));
    rd_status("st_flush_keeps_ovf", stat(1, 0, 1, 0));
    bus(1'b0, 2'd2, 32'h0, rd, er);
    chk("ctrl_flush_reads0", rd, ctrl(0, 0, 1, 0, 0));
    wr(2'd1, 32'h4);
    rd_status("st_clean", stat(1, 0, 0, 0));
    bus(1'b0, 2'd0, 32'h0, rd, er);
    chk("data_read0", rd, 32'h0);
    bus(1'b0, 2'd3, 32'h0, rd, er);
    chk("rsvd_read0", rd, 32'h0);
    chk("rsvd_read_err", {31'h0, er}, 32'h0);
    bus(1'b1, 2'd3, 32'h1234, rd, er);
    chk("rsvd_write_err", {31'h0, er}, 32'h1);
    repeat (3) @(negedge clk);
    clear_mon();

    // ---- flush mid-DRIVE ----
    wr(2'd2, ctrl(0, 0, 4, 0, 0));
    wr(2'd0, 32'h11); wr(2'd0, 32'h22); wr(2'd0, 32'h33); wr(2'd0, 32'h44);
    wr(2'd2, ctrl(1, 0, 4, 0, 0));
    k = 0;
    while (!par_valid && k < 10) begin @(negedge clk); k++; end
    chk("flush_first", {24'h0, par}, 32'h11);
    wr(2'd2, ctrl(1, 1, 4, 0, 0));
    chk("flush_drop", {31'h0, par_valid}, 32'h0);
    rd_status("flush_empty", stat(1, 0, 0, 0));
    repeat (20) @(negedge clk);
    chk("flush_no_more", obs_b.size(), 1);
    wr(2'd2, ctrl(0, 0, 1, 0, 0));
    repeat (3) @(negedge clk);
    clear_mon();

    // ---- full FIFO, push on the pop cycle ----
    model.delete();
    wr(2'd2, ctrl(0, 0, 2, 0, 0));
    for (int i = 0; i < DEPTH; i++) begin
      exp_b = 8'($urandom);
      model.push_back(exp_b);
      wr(2'd0, {24'h0, exp_b});
    end
    wr(2'd2, ctrl(1, 0, 2, 0, 0));
    exp_b = 8'($urandom);
    model.push_back(exp_b);
    bus(1'b1, 2'd0, {24'h0, exp_b}, rd, er);
    chk("pushpop_err", {31'h0, er}, 32'h0);
    rd_status("pushpop_level", stat(0, 1, 0, DEPTH));
    wait_bytes(DEPTH + 1, 200);
    chk("pushpop_count", obs_b.size(), DEPTH + 1);
    for (int i = 0; i < obs_b.size() && i < model.size(); i++)
      chk("pushpop_byte", {24'h0, obs_b[i]}, {24'h0, model[i]});
    for (int i = 1; i < obs_rise.size(); i++)
      chk("min_period", obs_rise[i] - obs_rise[i-1], 3);
    wr(2'd2, ctrl(0, 0, 1, 0, 0));
    repeat (3) @(negedge clk);

    // ---- randomized rounds against the stream model ----
    for (int r = 0; r < 8; r++) begin
      hold = $urandom_range(0, 15);
      gap  = $urandom_range(0, 3);
      n    = $urandom_range(1, DEPTH);
      heff = (hold == 0) ? 1 : hold;
      model.delete();
      clear_mon();
      if (r < 5) begin
        // preload then release: strobes must run at full rate
        wr(2'd2, ctrl(0, 0, hold, gap, 0));
        for (int i = 0; i < n; i++) begin
          exp_b = 8'($urandom);
          model.push_back(exp_b);
          bus(1'b1, 2'd0, {24'h0, exp_b}, rd, er);
          chk("rnd_push_err", {31'h0, er}, 32'h0);
        end
        wr(2'd2, ctrl(1, 0, hold, gap, 0));
      end else begin
        // enabled while pushing with random spacing
        wr(2'd2, ctrl(1, 0, hold, gap, 0));
        for (int i = 0; i < n; i++) begin
          exp_b = 8'($urandom);
          model.push_back(exp_b);
          bus(1'b1, 2'd0, {24'h0, exp_b}, rd, er);
          chk("rnd_push_err", {31'h0, er}, 32'h0);
          repeat ($urandom_range(0, 8)) @(negedge clk);
        end
      end
      wait_bytes(n, n * 25 + 20);
      chk("rnd_count", obs_b.size(), n);
      for (int i = 0; i < obs_b.size() && i < n; i++)
        chk("rnd_byte", {24'h0, obs_b[i]}, {24'h0, model[i]});
      for (int i = 0; i < obs_len.size(); i++)
        chk("rnd_hold", obs_len[i], heff);
      if (r < 5)
        for (int i = 1; i < obs_rise.size(); i++)
          chk("rnd_period", obs_rise[i] - obs_rise[i-1], heff + gap + 1);
      wr(2'd2, ctrl(0, 0, 1, 0, 0));
      repeat (3) @(negedge clk);
    end

`ifdef PARO_FIFO_IRQ_EN
    // ---- interrupt threshold ----
    clear_mon();
    wr(2'd2, ctrl(0, 0, 4, 0, 1));
    wr(2'd0, 32'h01); wr(2'd0, 32'h02); wr(2'd0, 32'h03);
    @(negedge clk);
    chk("irq_low_disabled", {31'h0, irq}, 32'h0);
    wr(2'd2, ctrl(1, 0, 4, 0, 1));
    k = 0;
    while (!irq && k < 40) begin @(negedge clk); k++; end
    chk("irq_rise", {31'h0, irq}, 32'h1);
    chk("irq_at_level1", obs_b.size(), 2);
    bus(1'b0, 2'd1, 32'h0, rd, er);
    chk("irq_status_bit", rd & 32'h8, 32'h8);
    wr(2'd2, ctrl(0, 0, 1, 0, 0));
`endif

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
